// File: rtl/input_link_router_ingress_if.sv
// Link-side bundle of the router ingress stage: incoming link words, downstream
// pacing, stall inputs, and the assembled header / payload outputs.
interface input_link_router_ingress_if;
    logic [31:0]  in_data;
    logic         next_ready;
    logic         transmit_link_output_buffer_full;
    logic [3:0]   hardware_subunit_input_buffer_full;
    logic [127:0] header_out;
    logic [31:0]  payload_out;
    logic         ready;

    // Driver side: deserializer / downstream pacing / stall sources.
    modport master (
        output in_data,
        output next_ready,
        output transmit_link_output_buffer_full,
        output hardware_subunit_input_buffer_full,
        input  header_out,
        input  payload_out,
        input  ready
    );

    // Ingress block side.
    modport slave (
        input  in_data,
        input  next_ready,
        input  transmit_link_output_buffer_full,
        input  hardware_subunit_input_buffer_full,
        output header_out,
        output payload_out,
        output ready
    );
endinterface

// File: rtl/input_link_router_ingress.sv
// Ingress stage of an input-link router. Reassembles 3DW/4DW TLP headers from a
// 32-bit zero-separated link word stream, hands the 128-bit header downstream
// as a one-cycle pulse, then forwards the payload one DW at a time through a
// one-word pending buffer when downstream is not ready.
module input_link_router_ingress #(
    parameter int LINK_NUMBER      = 0,
    parameter int DATA_WIDTH       = 32,
    parameter int SUBUNIT_QUANTITY = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input_link_router_ingress_if.slave  link
);

    // Only a 32-bit link is supported; the other parameters are informational.
    if ((DATA_WIDTH != 32) || (LINK_NUMBER < 0) || (SUBUNIT_QUANTITY < 0)) begin : g_unsupported_cfg
    end

    typedef enum logic [2:0] {
        ST_HDR0     = 3'd0,
        ST_HDR1     = 3'd1,
        ST_HDR2     = 3'd2,
        ST_HDR3     = 3'd3,
        ST_HDR_DONE = 3'd4,
        ST_PAYLOAD  = 3'd5
    } state_e;

    // Wire order of DW0 is byte-reversed relative to the header layout.
    function automatic logic [31:0] byte_reverse(input logic [31:0] w);
        byte_reverse = {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_e         state_q,       state_d;
    logic [31:0]    prev_q,        prev_d;
    logic [127:0]   hdr_q,         hdr_d;
    logic           is_4dw_q,      is_4dw_d;
    logic           has_pl_q,      has_pl_d;
    logic [10:0]    cnt_q,         cnt_d;
    logic           pend_valid_q,  pend_valid_d;
    logic [31:0]    pend_data_q,   pend_data_d;
    logic [127:0]   header_out_q,  header_out_d;
    logic [31:0]    payload_out_q, payload_out_d;
    logic           ready_q,       ready_d;

    logic           stall_s;
    logic           capture_s;
    logic           hdr_complete_s;
    logic           handoff_s;
    logic           fwd_s;
    logic [31:0]    fwd_data_s;
    logic [2:0]     fmt_s;
    logic [9:0]     len_s;
    state_e         after_hdr_s;

    assign link.header_out  = header_out_q;
    assign link.payload_out = payload_out_q;
    assign link.ready       = ready_q;

    // Decode this edge's events: stall, word capture, header handoff, payload forward.
    always_comb begin
        stall_s     = link.transmit_link_output_buffer_full |
                      (|link.hardware_subunit_input_buffer_full);
        capture_s   = (link.in_data != 32'h0000_0000) && (prev_q == 32'h0000_0000) &&
                      !stall_s && ready_q;
        fmt_s       = link.in_data[7:5];
        len_s       = {link.in_data[17:16], link.in_data[31:24]};
        after_hdr_s = has_pl_q ? ST_PAYLOAD : ST_HDR0;
        case (state_q)
            ST_HDR2:     hdr_complete_s = capture_s && !is_4dw_q;
            ST_HDR3:     hdr_complete_s = capture_s;
            ST_HDR_DONE: hdr_complete_s = 1'b1;
            default:     hdr_complete_s = 1'b0;
        endcase
        handoff_s  = hdr_complete_s && link.next_ready && !stall_s;
        fwd_s      = (state_q == ST_PAYLOAD) && link.next_ready && !stall_s &&
                     (pend_valid_q || capture_s);
        fwd_data_s = pend_valid_q ? pend_data_q : link.in_data;
    end

    // Next-state logic of the header/payload sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR0: begin
                if (capture_s) state_d = ST_HDR1;
                else           state_d = ST_HDR0;
            end
            ST_HDR1: begin
                if (capture_s) state_d = ST_HDR2;
                else           state_d = ST_HDR1;
            end
            ST_HDR2: begin
                if (!capture_s)    state_d = ST_HDR2;
                else if (is_4dw_q) state_d = ST_HDR3;
                else if (handoff_s) state_d = after_hdr_s;
                else               state_d = ST_HDR_DONE;
            end
            ST_HDR3: begin
                if (!capture_s)     state_d = ST_HDR3;
                else if (handoff_s) state_d = after_hdr_s;
                else                state_d = ST_HDR_DONE;
            end
            ST_HDR_DONE: begin
                if (handoff_s) state_d = after_hdr_s;
                else           state_d = ST_HDR_DONE;
            end
            ST_PAYLOAD: begin
                if (fwd_s && (cnt_q == 11'd1)) state_d = ST_HDR0;
                else                           state_d = ST_PAYLOAD;
            end
            default: state_d = ST_HDR0;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        prev_d      = link.in_data;
        hdr_d       = hdr_q;
        is_4dw_d    = is_4dw_q;
        has_pl_d    = has_pl_q;
        cnt_d       = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;

        if (fwd_s) begin
            cnt_d = cnt_q - 11'd1;
        end else begin
            cnt_d = cnt_q;
        end

        if (capture_s) begin
            case (state_q)
                ST_HDR0: begin
                    hdr_d    = {96'h0, byte_reverse(link.in_data)};
                    is_4dw_d = fmt_s[0];
                    has_pl_d = fmt_s[1];
                    // A zero length field encodes the maximum of 1024 DWs.
                    cnt_d    = (len_s == 10'd0) ? 11'd1024 : {1'b0, len_s};
                end
                ST_HDR1: hdr_d[63:32]  = link.in_data;
                ST_HDR2: hdr_d[95:64]  = link.in_data;
                ST_HDR3: hdr_d[127:96] = link.in_data;
                default: hdr_d = hdr_q;
            endcase
        end else begin
            hdr_d = hdr_q;
        end

        // A payload DW that cannot go downstream now is parked until next_ready.
        if ((state_q == ST_PAYLOAD) && capture_s && !link.next_ready) begin
            pend_valid_d = 1'b1;
            pend_data_d  = link.in_data;
        end else if (fwd_s && pend_valid_q) begin
            pend_valid_d = 1'b0;
            pend_data_d  = 32'h0000_0000;
        end else begin
            pend_valid_d = pend_valid_q;
            pend_data_d  = pend_data_q;
        end

        header_out_d  = handoff_s ? hdr_d : 128'h0;
        payload_out_d = fwd_s ? fwd_data_s : 32'h0000_0000;
        ready_d       = !stall_s && (state_d != ST_HDR_DONE) && !pend_valid_d;
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q        <= 32'h0000_0000;
            hdr_q         <= 128'h0;
            is_4dw_q      <= 1'b0;
            has_pl_q      <= 1'b0;
            cnt_q         <= 11'd0;
            pend_valid_q  <= 1'b0;
            pend_data_q   <= 32'h0000_0000;
            header_out_q  <= 128'h0;
            payload_out_q <= 32'h0000_0000;
            ready_q       <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            hdr_q         <= hdr_d;
            is_4dw_q      <= is_4dw_d;
            has_pl_q      <= has_pl_d;
            cnt_q         <= cnt_d;
            pend_valid_q  <= pend_valid_d;
            pend_data_q   <= pend_data_d;
            header_out_q  <= header_out_d;
            payload_out_q <= payload_out_d;
            ready_q       <= ready_d;
        end
    end

endmodule

// File: tb/tb_input_link_router_ingress.sv
// Self-checking bench for input_link_router_ingress: directed TLP scenarios with
// a scoreboard of expected headers and payload DWs popped when the DUT emits them.
module tb_input_link_router_ingress;

    logic clk = 1'b0;
    logic rst_n;

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    input_link_router_ingress_if lnk();

    input_link_router_ingress #(
        .LINK_NUMBER      (0),
        .DATA_WIDTH       (32),
        .SUBUNIT_QUANTITY (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .link  (lnk)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_hdr_q[$];
    logic [31:0]  exp_pl_q[$];

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference header layout built from the wire words.
    function automatic logic [127:0] model_hdr(input logic [31:0] w0, input logic [31:0] w1,
                                               input logic [31:0] w2, input logic [31:0] w3,
                                               input bit four);
        logic [31:0] d3;
        d3 = four ? w3 : 32'h0;
        return {d3, w2, w1, w0[7:0], w0[15:8], w0[23:16], w0[31:24]};
    endfunction

    // Scoreboard: every nonzero output must match the next queued expectation.
    always @(posedge clk) begin
        #1;
        if (lnk.header_out != 128'h0) begin
            if (exp_hdr_q.size() > 0) check_eq("hdr_sb", lnk.header_out, exp_hdr_q.pop_front());
            else                      check_eq("hdr_unexpected", lnk.header_out, 128'h0);
        end
        if (lnk.payload_out != 32'h0) begin
            if (exp_pl_q.size() > 0) check_eq("pl_sb", {96'h0, lnk.payload_out}, {96'h0, exp_pl_q.pop_front()});
            else                     check_eq("pl_unexpected", {96'h0, lnk.payload_out}, 128'h0);
        end
    end

    // Present a word for one edge; returns 1 ns after that edge.
    task automatic send(input logic [31:0] w, input logic nr);
        @(negedge clk);
        lnk.in_data    = w;
        lnk.next_ready = nr;
        @(posedge clk);
        #1;
    endtask

    // Return the link to idle for one edge.
    task automatic idle(input logic nr);
        send(32'h0, nr);
    endtask

    task automatic run_3dw(input string tag);
        send(32'h0000000F, 1'b0);
        idle(1'b0);
        send(32'h22222222, 1'b1);
        check_eq({tag, "_after_dw1"}, lnk.header_out, 128'h0);
        idle(1'b1);
        exp_hdr_q.push_back(model_hdr(32'h0000000F, 32'h22222222, 32'h33333333, 32'h0, 1'b0));
        send(32'h33333333, 1'b1);
        check_eq({tag, "_hdr"}, lnk.header_out, 128'h00000000_33333333_22222222_0F000000);
        idle(1'b0);
        check_eq({tag, "_clear"}, lnk.header_out, 128'h0);
        check_eq({tag, "_ready"}, {127'h0, lnk.ready}, 128'h1);
    endtask

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        lnk.in_data = 32'h0;
        lnk.next_ready = 1'b0;
        lnk.transmit_link_output_buffer_full = 1'b0;
        lnk.hardware_subunit_input_buffer_full = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hdr", lnk.header_out, 128'h0);
        check_eq("rst_pl", {96'h0, lnk.payload_out}, 128'h0);
        check_eq("rst_ready", {127'h0, lnk.ready}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", {127'h0, lnk.ready}, 128'h1);

        // 3DW header, no payload.
        run_3dw("s1");

        // 4DW header, no payload, handoff delayed by next_ready.
        send(32'h0044442F, 1'b0); idle(1'b0);
        send(32'h55555555, 1'b0); idle(1'b0);
        send(32'h66666666, 1'b0); idle(1'b0);
        send(32'h77777777, 1'b0);
        check_eq("4dw_wait_hdr", lnk.header_out, 128'h0);
        check_eq("4dw_wait_ready", {127'h0, lnk.ready}, 128'h0);
        exp_hdr_q.push_back(model_hdr(32'h0044442F, 32'h55555555, 32'h66666666, 32'h77777777, 1'b1));
        idle(1'b1);
        check_eq("4dw_hdr", lnk.header_out, 128'h77777777_66666666_55555555_2F444400);
        idle(1'b1);
        check_eq("4dw_clear", lnk.header_out, 128'h0);
        check_eq("4dw_ready", {127'h0, lnk.ready}, 128'h1);

        // 4DW header with two payload DWs.
        send(32'h0200006F, 1'b1); idle(1'b1);
        send(32'h11111111, 1'b1); idle(1'b1);
        send(32'h22222222, 1'b1);
        check_eq("pl_hdr_early", lnk.header_out, 128'h0);
        idle(1'b1);
        exp_hdr_q.push_back(model_hdr(32'h0200006F, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1));
        send(32'h33333333, 1'b1);
        check_eq("pl_hdr", lnk.header_out, 128'h33333333_22222222_11111111_6F000002);
        idle(1'b1);
        exp_pl_q.push_back(32'h40404040);
        send(32'h40404040, 1'b1);
        check_eq("pl_dw0", {96'h0, lnk.payload_out}, {96'h0, 32'h40404040});
        idle(1'b1);
        check_eq("pl_gap", {96'h0, lnk.payload_out}, 128'h0);
        exp_pl_q.push_back(32'h50505050);
        send(32'h50505050, 1'b1);
        check_eq("pl_dw1", {96'h0, lnk.payload_out}, {96'h0, 32'h50505050});
        idle(1'b1);
        check_eq("pl_end_ready", {127'h0, lnk.ready}, 128'h1);

        // Post-payload regression: FSM must be back at DW0.
        run_3dw("s4");

        // Back-pressure on a single-DW payload (3DW, len 1).
        send(32'h01000040, 1'b1); idle(1'b1);
        send(32'hAAAA0001, 1'b1); idle(1'b1);
        exp_hdr_q.push_back(model_hdr(32'h01000040, 32'hAAAA0001, 32'hAAAA0002, 32'h0, 1'b0));
        send(32'hAAAA0002, 1'b1);
        check_eq("bp_hdr", lnk.header_out, 128'h00000000_AAAA0002_AAAA0001_40000001);
        idle(1'b1);
        send(32'hABCD1234, 1'b0);
        check_eq("bp_ready", {127'h0, lnk.ready}, 128'h0);
        check_eq("bp_pl_held", {96'h0, lnk.payload_out}, 128'h0);
        idle(1'b0);
        check_eq("bp_ready_hold", {127'h0, lnk.ready}, 128'h0);
        exp_pl_q.push_back(32'hABCD1234);
        idle(1'b1);
        check_eq("bp_pl_fwd", {96'h0, lnk.payload_out}, {96'h0, 32'hABCD1234});
        check_eq("bp_ready_back", {127'h0, lnk.ready}, 128'h1);

        // Stall mid-header: a word presented while stalled is not captured.
        send(32'h0000000F, 1'b1); idle(1'b1);
        @(negedge clk);
        lnk.hardware_subunit_input_buffer_full = 4'b0100;
        @(posedge clk);
        #1;
        check_eq("stall_ready", {127'h0, lnk.ready}, 128'h0);
        send(32'h99999999, 1'b1);
        check_eq("stall_no_hdr", lnk.header_out, 128'h0);
        check_eq("stall_ready2", {127'h0, lnk.ready}, 128'h0);
        idle(1'b1);
        @(negedge clk);
        lnk.hardware_subunit_input_buffer_full = 4'b0000;
        @(posedge clk);
        #1;
        check_eq("unstall_ready", {127'h0, lnk.ready}, 128'h1);
        send(32'h22222222, 1'b1); idle(1'b1);
        exp_hdr_q.push_back(model_hdr(32'h0000000F, 32'h22222222, 32'h33333333, 32'h0, 1'b0));
        send(32'h33333333, 1'b1);
        check_eq("stall_resume_hdr", lnk.header_out, 128'h00000000_33333333_22222222_0F000000);
        idle(1'b1);

        // Reset asserted mid-payload clears outputs immediately.
        send(32'h02000040, 1'b1); idle(1'b1);
        send(32'h12345678, 1'b1); idle(1'b1);
        exp_hdr_q.push_back(model_hdr(32'h02000040, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0));
        send(32'h9ABCDEF0, 1'b1);
        idle(1'b1);
        exp_pl_q.push_back(32'h11112222);
        send(32'h11112222, 1'b1);
        check_eq("rst_mid_pl_before", {96'h0, lnk.payload_out}, {96'h0, 32'h11112222});
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_pl", {96'h0, lnk.payload_out}, 128'h0);
        check_eq("rst_mid_hdr", lnk.header_out, 128'h0);
        check_eq("rst_mid_ready", {127'h0, lnk.ready}, 128'h0);
        lnk.in_data = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rerst_ready", {127'h0, lnk.ready}, 128'h1);

        check_eq("hdr_sb_drained", 128'(exp_hdr_q.size()), 128'h0);
        check_eq("pl_sb_drained", 128'(exp_pl_q.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
